// File: rtl/plotter_pkg.sv
// Shared types and constants for the plotter step/direction generator.
// Status bit indices are also used by the register block.
package plotter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
  } step_state_t;

  localparam int STEPS_W_DEF   = 32;
  localparam int CNT_W_DEF     = 32;
  localparam int POS_W_DEF     = 32;
  localparam int DIR_SETUP_DEF = 200;
  localparam int MIN_HALF_DEF  = 50;

  localparam int BUSY    = 0;
  localparam int ABORTED = 1;
  localparam int LIMIT   = 2;

endpackage

// File: rtl/plotter_step_gen_if.sv
// Motion command handshake between the register block
// and the step generator.
interface plotter_step_gen_if #(
  parameter int STEPS_W = 32,
  parameter int CNT_W   = 32
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [STEPS_W-1:0] cmd_steps;
  logic [CNT_W-1:0]   cmd_half_period;
  logic               cmd_dir;

  modport master (
    output cmd_valid,
    output cmd_steps,
    output cmd_half_period,
    output cmd_dir,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_steps,
    input  cmd_half_period,
    input  cmd_dir,
    output cmd_ready
  );

endinterface

// File: rtl/plotter_step_timer.sv
// Loadable down-counter; expired while the count sits at zero.
// Times both the DIR setup window and each STEP half-period.
module plotter_step_timer #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // load wins, otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/plotter_step_gen.sv
// Step/direction pulse generator, one instance per axis.
// Optional soft limits: PLOTTER_STEP_GEN_SOFT_LIMIT_EN.
module plotter_step_gen
  import plotter_pkg::*;
#(
  parameter int STEPS_W       = STEPS_W_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int POS_W         = POS_W_DEF,
  parameter int DIR_SETUP_CYC = DIR_SETUP_DEF,
  parameter int MIN_HALF      = MIN_HALF_DEF
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  plotter_step_gen_if.slave       cmd,
  input  logic                    abort,
  input  logic                    drv_enable,
`ifdef PLOTTER_STEP_GEN_SOFT_LIMIT_EN
  input  logic signed [POS_W-1:0] pos_min,
  input  logic signed [POS_W-1:0] pos_max,
  output logic                    limit_hit,
`endif
  output logic                    step_out,
  output logic                    dir_out,
  output logic                    en_n_out,
  output logic                    busy,
  output logic                    done_pulse,
  output logic                    aborted,
  output logic [STEPS_W-1:0]      steps_remaining,
  output logic signed [POS_W-1:0] position
);

  localparam logic signed [POS_W-1:0] ONE_P = 1;

  step_state_t state_q, state_d;

  logic [STEPS_W-1:0]      remain_q, remain_d;
  logic [CNT_W-1:0]        half_q, half_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic step_q, step_d;
  logic dir_q, dir_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic abt_q, abt_d;
  logic pend_q, pend_d;
  logic rdy_q, rdy_d;
  logic en_n_q;

  logic [CNT_W-1:0]        half_eff;
  logic signed [POS_W-1:0] pos_nxt;
  logic                    accept;
  logic                    stop;
  logic                    lim_block;
  logic                    go_high;
  logic                    go_idle;
  logic                    tmr_load;
  logic [CNT_W-1:0]        tmr_val;
  logic                    tmr_exp;

  assign accept   = cmd.cmd_valid && rdy_q;
  assign stop     = abort || !drv_enable;
  assign half_eff = (cmd.cmd_half_period < CNT_W'(MIN_HALF))
                  ? CNT_W'(MIN_HALF) : cmd.cmd_half_period;
  assign pos_nxt  = dir_q ? pos_q + ONE_P : pos_q - ONE_P;

`ifdef PLOTTER_STEP_GEN_SOFT_LIMIT_EN
  localparam logic signed [POS_W:0] ONE_X = 1;

  logic signed [POS_W:0] pos_x, pos_try, lo_x, hi_x;
  logic                  lim_q, lim_d;

  // one extra bit so the bound test never sees a wrapped value
  assign pos_x     = {pos_q[POS_W-1], pos_q};
  assign pos_try   = dir_q ? pos_x + ONE_X : pos_x - ONE_X;
  assign lo_x      = {pos_min[POS_W-1], pos_min};
  assign hi_x      = {pos_max[POS_W-1], pos_max};
  assign lim_block = (pos_try < lo_x) || (pos_try > hi_x);
  assign limit_hit = lim_q;
`else
  assign lim_block = 1'b0;
`endif

  plotter_step_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .load_i    (tmr_load),
    .value_i   (tmr_val),
    .expired_o (tmr_exp)
  );

  // next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    half_d   = half_q;
    pos_d    = pos_q;
    step_d   = step_q;
    dir_d    = dir_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    abt_d    = abt_q;
    pend_d   = pend_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    go_high  = 1'b0;
    go_idle  = 1'b0;
`ifdef PLOTTER_STEP_GEN_SOFT_LIMIT_EN
    lim_d    = lim_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          remain_d = cmd.cmd_steps;
          half_d   = half_eff;
          abt_d    = 1'b0;
          pend_d   = 1'b0;
`ifdef PLOTTER_STEP_GEN_SOFT_LIMIT_EN
          lim_d    = 1'b0;
`endif
          if (cmd.cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d = 1'b1;
            if (cmd.cmd_dir != dir_q) begin
              dir_d    = cmd.cmd_dir;
              state_d  = SETUP;
              tmr_load = 1'b1;
              tmr_val  = CNT_W'(DIR_SETUP_CYC - 1);
            end else begin
              go_high = 1'b1;
            end
          end
        end
      end
      SETUP: begin
        if (stop) begin
          go_idle = 1'b1;
          abt_d   = 1'b1;
        end else if (tmr_exp) begin
          go_high = 1'b1;
        end
      end
      HIGH: begin
        if (stop) begin
          pend_d = 1'b1;
        end
        if (tmr_exp) begin
          step_d = 1'b0;
          if (stop || pend_q) begin
            go_idle = 1'b1;
            abt_d   = 1'b1;
          end else begin
            state_d  = LOW;
            tmr_load = 1'b1;
            tmr_val  = half_q - CNT_W'(1);
          end
        end
      end
      LOW: begin
        if (stop) begin
          go_idle = 1'b1;
          abt_d   = 1'b1;
        end else if (tmr_exp) begin
          if (remain_q == '0) begin
            go_idle = 1'b1;
          end else begin
            go_high = 1'b1;
          end
        end
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase
    if (go_high) begin
      if (lim_block) begin
        go_idle = 1'b1;
`ifdef PLOTTER_STEP_GEN_SOFT_LIMIT_EN
        lim_d   = 1'b1;
`endif
      end else begin
        state_d  = HIGH;
        step_d   = 1'b1;
        pos_d    = pos_nxt;
        remain_d = remain_d - STEPS_W'(1);
        tmr_load = 1'b1;
        tmr_val  = half_d - CNT_W'(1);
      end
    end
    if (go_idle) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      step_d  = 1'b0;
      pend_d  = 1'b0;
    end
    rdy_d = (state_d == IDLE);
  end

  // state and output registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= IDLE;
      remain_q <= '0;
      half_q   <= '0;
      pos_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abt_q    <= 1'b0;
      pend_q   <= 1'b0;
      rdy_q    <= 1'b0;
      en_n_q   <= 1'b1;
`ifdef PLOTTER_STEP_GEN_SOFT_LIMIT_EN
      lim_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      half_q   <= half_d;
      pos_q    <= pos_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      abt_q    <= abt_d;
      pend_q   <= pend_d;
      rdy_q    <= rdy_d;
      en_n_q   <= ~drv_enable;
`ifdef PLOTTER_STEP_GEN_SOFT_LIMIT_EN
      lim_q    <= lim_d;
`endif
    end
  end

  assign cmd.cmd_ready   = rdy_q;
  assign step_out        = step_q;
  assign dir_out         = dir_q;
  assign en_n_out        = en_n_q;
  assign busy            = busy_q;
  assign done_pulse      = done_q;
  assign aborted         = abt_q;
  assign steps_remaining = remain_q;
  assign position        = pos_q;

endmodule

// File: tb/tb_plotter_step_gen.sv
// Self-checking bench for plotter_step_gen.
// Build with PLOTTER_STEP_GEN_SOFT_LIMIT_EN to cover soft limits.
module tb_plotter_step_gen;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic abort = 1'b0;
  logic drv_enable = 1'b1;
  logic step_out, dir_out, en_n_out, busy, done_pulse, aborted;
  logic [31:0] steps_remaining;
  logic signed [31:0] position;
`ifdef PLOTTER_STEP_GEN_SOFT_LIMIT_EN
  logic signed [31:0] pos_min = -32'sd1000000;
  logic signed [31:0] pos_max = 32'sd1000000;
  logic limit_hit;
`endif

  plotter_step_gen_if cmd ();

  plotter_step_gen dut (
    .ACLK            (ACLK),
    .ARESET          (ARESET),
    .cmd             (cmd),
    .abort           (abort),
    .drv_enable      (drv_enable),
`ifdef PLOTTER_STEP_GEN_SOFT_LIMIT_EN
    .pos_min         (pos_min),
    .pos_max         (pos_max),
    .limit_hit       (limit_hit),
`endif
    .step_out        (step_out),
    .dir_out         (dir_out),
    .en_n_out        (en_n_out),
    .busy            (busy),
    .done_pulse      (done_pulse),
    .aborted         (aborted),
    .steps_remaining (steps_remaining),
    .position        (position)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad = 0;
  int exp_pos = 0;
  logic exp_dir = 1'b0;

  // observations of one move, index k = cycles since the accept cycle began
  int o_first, o_np, o_hmin, o_hmax, o_lmin, o_lmax;
  int o_done, o_donek, o_busy, o_dirchg, o_rdyb, o_to;
  logic o_en_n;

  task automatic run_move(input int st, input int hp, input logic d,
                          input int ab_pulse, input int ab_off,
                          input int en_k, input int ign_k,
                          input int tail, input int budget);
    int rise_k, fall_k, ab_k;
    logic prev_step, prev_dir;
    o_first = -1; o_np = 0; o_hmin = 1 << 30; o_hmax = 0;
    o_lmin = 1 << 30; o_lmax = 0; o_done = 0; o_donek = -1;
    o_busy = 0; o_dirchg = 0; o_rdyb = 0; o_to = 0; o_en_n = 1'bx;
    rise_k = 0; fall_k = 0; ab_k = -1;
    prev_step = step_out; prev_dir = dir_out;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_steps = st;
    cmd.cmd_half_period = hp;
    cmd.cmd_dir = d;
    for (int k = 1; k <= budget; k++) begin
      @(negedge ACLK);
      if (k == 1) cmd.cmd_valid = 1'b0;
      abort = 1'b0;
      drv_enable = 1'b1;
      if (k == en_k + 1) o_en_n = en_n_out;
      if (step_out && !prev_step) begin
        o_np++;
        if (o_np == 1) o_first = k;
        else begin
          if (k - fall_k < o_lmin) o_lmin = k - fall_k;
          if (k - fall_k > o_lmax) o_lmax = k - fall_k;
        end
        rise_k = k;
        if (o_np == ab_pulse) ab_k = k + ab_off;
      end
      if (!step_out && prev_step) begin
        if (k - rise_k < o_hmin) o_hmin = k - rise_k;
        if (k - rise_k > o_hmax) o_hmax = k - rise_k;
        fall_k = k;
      end
      if (k > 1 && dir_out !== prev_dir) o_dirchg++;
      prev_dir = dir_out;
      prev_step = step_out;
      if (busy) o_busy++;
      if (busy && cmd.cmd_ready) o_rdyb++;
      if (done_pulse) begin
        o_done++;
        if (o_donek < 0) o_donek = k;
      end
      if (k == ab_k) abort = 1'b1;
      if (k == en_k) drv_enable = 1'b0;
      if (k == ign_k) begin
        cmd.cmd_valid = 1'b1;
        cmd.cmd_steps = st + 3;
      end
      if (k == ign_k + 5) cmd.cmd_valid = 1'b0;
      if (o_donek >= 0 && k >= o_donek + tail) break;
    end
    cmd.cmd_valid = 1'b0;
    if (o_donek < 0) o_to = 1;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    cmd.cmd_valid = 1'b0;
    repeat (2) @(negedge ACLK);
    total++; if (step_out !== 1'b0) begin bad++; $display("FAIL rst_step got=%b want=0", step_out); end
    total++; if (dir_out !== 1'b0) begin bad++; $display("FAIL rst_dir got=%b want=0", dir_out); end
    total++; if (en_n_out !== 1'b1) begin bad++; $display("FAIL rst_en_n got=%b want=1", en_n_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done_pulse !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done_pulse); end
    total++; if (aborted !== 1'b0) begin bad++; $display("FAIL rst_aborted got=%b want=0", aborted); end
    total++; if (steps_remaining !== 32'd0) begin bad++; $display("FAIL rst_remain got=%0d want=0", steps_remaining); end
    total++; if (position !== 32'sd0) begin bad++; $display("FAIL rst_pos got=%0d want=0", position); end
    total++; if (cmd.cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", cmd.cmd_ready); end
    ARESET = 1'b0;
    @(negedge ACLK);
    total++; if (cmd.cmd_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", cmd.cmd_ready); end
    total++; if (en_n_out !== 1'b0) begin bad++; $display("FAIL post_rst_en_n got=%b want=0", en_n_out); end
    exp_pos = 0;
    exp_dir = 1'b0;
  endtask

  task automatic test_basic();
    int wp;
    wp = exp_dir ? exp_pos + 4 : exp_pos - 4;
    run_move(4, 100, exp_dir, 0, 0, 0, 0, 3, 900);
    total++; if (o_to !== 0) begin bad++; $display("FAIL basic_timeout got=%0d want=0", o_to); end
    total++; if (o_np !== 4) begin bad++; $display("FAIL basic_pulses got=%0d want=4", o_np); end
    total++; if (o_first !== 1) begin bad++; $display("FAIL basic_first got=%0d want=1", o_first); end
    total++; if (o_hmin !== 100 || o_hmax !== 100) begin bad++; $display("FAIL basic_high got=%0d..%0d want=100", o_hmin, o_hmax); end
    total++; if (o_lmin !== 100 || o_lmax !== 100) begin bad++; $display("FAIL basic_low got=%0d..%0d want=100", o_lmin, o_lmax); end
    total++; if (o_done !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d want=1", o_done); end
    total++; if (o_busy !== 800) begin bad++; $display("FAIL basic_busy got=%0d want=800", o_busy); end
    total++; if (o_donek !== 801) begin bad++; $display("FAIL basic_done_at got=%0d want=801", o_donek); end
    total++; if (position !== wp) begin bad++; $display("FAIL basic_pos got=%0d want=%0d", position, wp); end
    exp_pos = wp;
  endtask

  task automatic test_dir_change();
    logic nd;
    int wp;
    nd = ~exp_dir;
    wp = nd ? exp_pos + 1 : exp_pos - 1;
    run_move(1, 60, nd, 0, 0, 0, 0, 3, 400);
    total++; if (o_first !== 201) begin bad++; $display("FAIL dirchg_first got=%0d want=201", o_first); end
    total++; if (o_np !== 1) begin bad++; $display("FAIL dirchg_pulses got=%0d want=1", o_np); end
    total++; if (o_hmax !== 60) begin bad++; $display("FAIL dirchg_high got=%0d want=60", o_hmax); end
    total++; if (o_dirchg !== 0) begin bad++; $display("FAIL dirchg_stable got=%0d want=0", o_dirchg); end
    total++; if (dir_out !== nd) begin bad++; $display("FAIL dirchg_dir got=%b want=%b", dir_out, nd); end
    total++; if (position !== wp) begin bad++; $display("FAIL dirchg_pos got=%0d want=%0d", position, wp); end
    exp_pos = wp;
    exp_dir = nd;
  endtask

  task automatic test_clamp();
    int wp;
    wp = exp_dir ? exp_pos + 2 : exp_pos - 2;
    run_move(2, 10, exp_dir, 0, 0, 0, 0, 3, 300);
    total++; if (o_hmin !== 50 || o_hmax !== 50) begin bad++; $display("FAIL clamp_high got=%0d..%0d want=50", o_hmin, o_hmax); end
    total++; if (o_lmin !== 50) begin bad++; $display("FAIL clamp_low got=%0d want=50", o_lmin); end
    total++; if (o_busy !== 200) begin bad++; $display("FAIL clamp_busy got=%0d want=200", o_busy); end
    total++; if (position !== wp) begin bad++; $display("FAIL clamp_pos got=%0d want=%0d", position, wp); end
    exp_pos = wp;
  endtask

  task automatic test_zero();
    run_move(0, 80, ~exp_dir, 0, 0, 0, 0, 3, 50);
    total++; if (o_donek !== 1) begin bad++; $display("FAIL zero_done_at got=%0d want=1", o_donek); end
    total++; if (o_busy !== 0) begin bad++; $display("FAIL zero_busy got=%0d want=0", o_busy); end
    total++; if (o_np !== 0) begin bad++; $display("FAIL zero_pulses got=%0d want=0", o_np); end
    total++; if (position !== exp_pos) begin bad++; $display("FAIL zero_pos got=%0d want=%0d", position, exp_pos); end
    total++; if (dir_out !== exp_dir) begin bad++; $display("FAIL zero_dir got=%b want=%b", dir_out, exp_dir); end
  endtask

  task automatic test_abort();
    int h, off, wp;
    h = $urandom_range(50, 90);
    off = $urandom_range(1, h - 2);
    wp = exp_dir ? exp_pos + 2 : exp_pos - 2;
    run_move(10, h, exp_dir, 2, off, 0, 0, 3, 2000);
    total++; if (o_np !== 2) begin bad++; $display("FAIL abort_pulses got=%0d want=2", o_np); end
    total++; if (o_hmin !== h || o_hmax !== h) begin bad++; $display("FAIL abort_high got=%0d..%0d want=%0d", o_hmin, o_hmax, h); end
    total++; if (o_busy !== 3 * h) begin bad++; $display("FAIL abort_busy got=%0d want=%0d", o_busy, 3 * h); end
    total++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort_flag got=%b want=1", aborted); end
    total++; if (steps_remaining !== 32'd8) begin bad++; $display("FAIL abort_remain got=%0d want=8", steps_remaining); end
    total++; if (position !== wp) begin bad++; $display("FAIL abort_pos got=%0d want=%0d", position, wp); end
    total++; if (o_done !== 1) begin bad++; $display("FAIL abort_done_cnt got=%0d want=1", o_done); end
    exp_pos = wp;
  endtask

  task automatic test_enable_drop();
    logic nd;
    nd = ~exp_dir;
    run_move(3, 50, nd, 0, 0, 50, 0, 3, 400);
    total++; if (o_np !== 0) begin bad++; $display("FAIL endrop_pulses got=%0d want=0", o_np); end
    total++; if (o_busy !== 50) begin bad++; $display("FAIL endrop_busy got=%0d want=50", o_busy); end
    total++; if (aborted !== 1'b1) begin bad++; $display("FAIL endrop_flag got=%b want=1", aborted); end
    total++; if (o_en_n !== 1'b1) begin bad++; $display("FAIL endrop_en_n got=%b want=1", o_en_n); end
    total++; if (position !== exp_pos) begin bad++; $display("FAIL endrop_pos got=%0d want=%0d", position, exp_pos); end
    exp_dir = nd;
  endtask

  task automatic test_ignore_busy();
    int wp;
    wp = exp_dir ? exp_pos + 3 : exp_pos - 3;
    run_move(3, 50, exp_dir, 0, 0, 0, 20, 5, 400);
    total++; if (o_np !== 3) begin bad++; $display("FAIL ign_pulses got=%0d want=3", o_np); end
    total++; if (o_rdyb !== 0) begin bad++; $display("FAIL ign_ready_busy got=%0d want=0", o_rdyb); end
    total++; if (o_done !== 1) begin bad++; $display("FAIL ign_done_cnt got=%0d want=1", o_done); end
    total++; if (aborted !== 1'b0) begin bad++; $display("FAIL ign_aborted got=%b want=0", aborted); end
    total++; if (position !== wp) begin bad++; $display("FAIL ign_pos got=%0d want=%0d", position, wp); end
    exp_pos = wp;
  endtask

  task automatic test_back_to_back();
    int wp;
    wp = exp_dir ? exp_pos + 2 : exp_pos - 2;
    run_move(2, 50, exp_dir, 0, 0, 0, 0, 0, 300);
    total++; if (o_np !== 2) begin bad++; $display("FAIL b2b_a_pulses got=%0d want=2", o_np); end
    wp = exp_dir ? wp + 1 : wp - 1;
    run_move(1, 60, exp_dir, 0, 0, 0, 0, 3, 300);
    total++; if (o_first !== 1) begin bad++; $display("FAIL b2b_b_first got=%0d want=1", o_first); end
    total++; if (o_busy !== 120) begin bad++; $display("FAIL b2b_b_busy got=%0d want=120", o_busy); end
    total++; if (position !== wp) begin bad++; $display("FAIL b2b_pos got=%0d want=%0d", position, wp); end
    exp_pos = wp;
  endtask

  task automatic test_random();
    int st, hp, h, dc, wb, wf;
    logic d;
    for (int i = 0; i < 6; i++) begin
      st = $urandom_range(0, 5);
      hp = $urandom_range(20, 110);
      d = 1'($urandom_range(0, 1));
      h = (hp < 50) ? 50 : hp;
      dc = (st != 0 && d != exp_dir) ? 1 : 0;
      wb = (st == 0) ? 0 : dc * 200 + 2 * h * st;
      wf = (st == 0) ? -1 : dc * 200 + 1;
      run_move(st, hp, d, 0, 0, 0, 0, 2, wb + 40);
      if (st != 0) exp_dir = d;
      exp_pos = exp_dir ? exp_pos + st : exp_pos - st;
      total++; if (o_to !== 0) begin bad++; $display("FAIL rnd%0d_timeout got=%0d want=0", i, o_to); end
      total++; if (o_np !== st) begin bad++; $display("FAIL rnd%0d_pulses got=%0d want=%0d", i, o_np, st); end
      total++; if (o_first !== wf) begin bad++; $display("FAIL rnd%0d_first got=%0d want=%0d", i, o_first, wf); end
      total++; if (o_busy !== wb) begin bad++; $display("FAIL rnd%0d_busy got=%0d want=%0d", i, o_busy, wb); end
      total++; if (o_donek !== wb + 1) begin bad++; $display("FAIL rnd%0d_done_at got=%0d want=%0d", i, o_donek, wb + 1); end
      total++; if (position !== exp_pos) begin bad++; $display("FAIL rnd%0d_pos got=%0d want=%0d", i, position, exp_pos); end
      total++; if (dir_out !== exp_dir) begin bad++; $display("FAIL rnd%0d_dir got=%b want=%b", i, dir_out, exp_dir); end
      if (st > 0) begin
        total++; if (o_hmin !== h || o_hmax !== h) begin bad++; $display("FAIL rnd%0d_high got=%0d..%0d want=%0d", i, o_hmin, o_hmax, h); end
      end
      if (st > 1) begin
        total++; if (o_lmin !== h || o_lmax !== h) begin bad++; $display("FAIL rnd%0d_low got=%0d..%0d want=%0d", i, o_lmin, o_lmax, h); end
      end
    end
  endtask

  task automatic test_reset_mid();
    cmd.cmd_valid = 1'b1;
    cmd.cmd_steps = 5;
    cmd.cmd_half_period = 50;
    cmd.cmd_dir = exp_dir;
    @(negedge ACLK);
    cmd.cmd_valid = 1'b0;
    repeat (9) @(negedge ACLK);
    total++; if (step_out !== 1'b1) begin bad++; $display("FAIL rstmid_pre_step got=%b want=1", step_out); end
    ARESET = 1'b1;
    @(negedge ACLK);
    total++; if (step_out !== 1'b0) begin bad++; $display("FAIL rstmid_step got=%b want=0", step_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (position !== 32'sd0) begin bad++; $display("FAIL rstmid_pos got=%0d want=0", position); end
    total++; if (dir_out !== 1'b0) begin bad++; $display("FAIL rstmid_dir got=%b want=0", dir_out); end
    total++; if (steps_remaining !== 32'd0) begin bad++; $display("FAIL rstmid_remain got=%0d want=0", steps_remaining); end
    ARESET = 1'b0;
    @(negedge ACLK);
    exp_pos = 0;
    exp_dir = 1'b0;
  endtask

`ifdef PLOTTER_STEP_GEN_SOFT_LIMIT_EN
  task automatic test_limit();
    pos_max = 32'sd2;
    run_move(5, 50, 1'b1, 0, 0, 0, 0, 3, 700);
    total++; if (o_np !== 2) begin bad++; $display("FAIL limit_pulses got=%0d want=2", o_np); end
    total++; if (limit_hit !== 1'b1) begin bad++; $display("FAIL limit_hit got=%b want=1", limit_hit); end
    total++; if (aborted !== 1'b0) begin bad++; $display("FAIL limit_aborted got=%b want=0", aborted); end
    total++; if (o_done !== 1) begin bad++; $display("FAIL limit_done_cnt got=%0d want=1", o_done); end
    total++; if (o_busy !== 400) begin bad++; $display("FAIL limit_busy got=%0d want=400", o_busy); end
    total++; if (position !== 32'sd2) begin bad++; $display("FAIL limit_pos got=%0d want=2", position); end
    pos_max = 32'sd1000000;
  endtask
`endif

  initial begin
    cmd.cmd_valid = 1'b0;
    cmd.cmd_steps = '0;
    cmd.cmd_half_period = '0;
    cmd.cmd_dir = 1'b0;
    @(negedge ACLK);
    test_reset();
    test_basic();
    test_dir_change();
    test_clamp();
    test_zero();
    test_abort();
    test_enable_drop();
    test_ignore_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef PLOTTER_STEP_GEN_SOFT_LIMIT_EN
    test_limit();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
